instruction_cache: RTL
======================

Name: instruction_cache

Overview:
Direct-mapped, read-only instruction cache directly upstream of instruction_fetch_stage. It serves the fetch stage's 30-bit word address with a combinational hit path and drops bits [1:0], which are always 2'b11 for RV32 non-compressed instructions. On a miss it deasserts ready and refills the whole line from memory over a request/grant/rvalid word interface. It also provides whole-cache invalidation for fence.i.

Parameters:
LINES, 64, number of cache lines; power of two, at least 2.
LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.
(Derived localparams: OFFSET_W = log2(LINE_WORDS); INDEX_W = log2(LINES); TAG_W = 30 - INDEX_W - OFFSET_W.)

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  reset, asynchronous, active-low.
addr_i  in  30 [31:2]  fetch word address; drives the fetch stage's cache_address_o.
data_o  out  30 [31:2]  instruction bits [31:2] of the addressed word.
ready_o  out  1  hit, data_o valid this cycle; drives the fetch stage's cache_blocking_n_i.
invalidate_i  in  1  single-cycle pulse that clears all valid bits (fence.i).
mem_req_o  out  1  word read request.
mem_addr_o  out  30 [31:2]  requested word address.
mem_gnt_i  in  1  request accepted this cycle.
mem_rvalid_i  in  1  read data valid; responses arrive in request order.
mem_rdata_i  in  32  read data word.

Behaviour:
- Address split: offset = addr_i[OFFSET_W+1:2], index = next INDEX_W bits, tag = addr_i[31:32-TAG_W].
- Storage:
  - valid[LINES] in flops.
  - tag array and data array with asynchronous read and synchronous write.
  - Data array stores only [31:2] of each word.
- Hit = valid[index] & (tag_array[index] == tag).
- ready_o = (state == IDLE) & hit & !invalidate_i. It is combinational, zero latency.
- data_o = data_array[index][offset], combinational. It is don't-care while ready_o = 0.
- Reset (asynchronous, rst_n_i = 0):
  - all valid bits cleared, state = IDLE;
  - req_cnt = resp_cnt = 0, mem_req_o = 0, mem_addr_o = 0;
  - ready_o = 0 through reset because every line is invalid.
  - Reset asserted mid-refill aborts the refill; no line becomes valid.
- FSM:
  - IDLE:
    - On miss with no invalidate_i: latch miss_tag and miss_index from addr_i, clear req_cnt and resp_cnt, go to REFILL.
    - On hit: stay in IDLE.
  - REFILL:
    - mem_req_o = 1 while req_cnt < LINE_WORDS.
    - mem_addr_o = {miss_tag, miss_index, req_cnt[OFFSET_W-1:0]}; words are fetched in order starting at word 0.
    - req_cnt increments on mem_gnt_i.
    - On each mem_rvalid_i, write mem_rdata_i[31:2] to data_array[miss_index][resp_cnt] and increment resp_cnt. mem_rdata_i[1:0] is discarded.
    - rvalid may coincide with a grant and may lag it by any number of cycles.
    - On the last rvalid (resp_cnt == LINE_WORDS-1): write tag_array[miss_index] = miss_tag, set valid[miss_index] unless a drop is pending, go to IDLE.
    - The refilled address hits on the first IDLE cycle.
  - mem_req_o is 0 outside REFILL and after all LINE_WORDS requests are granted.
- Invalidate:
  - In IDLE: all valid bits clear at the next edge. ready_o is forced low in the same cycle.
  - In REFILL: all valid bits clear immediately and a drop flag is set. The refill completes but its line is not marked valid. The drop flag clears on return to IDLE.
  - Invalidate on the refill's final-rvalid cycle also drops the line.
- addr_i may change during REFILL, for example on a branch. The refill still completes into the latched line. IDLE then re-evaluates the new addr_i, and a miss there starts a new refill.
- Counters are OFFSET_W+1 bits wide so they can reach LINE_WORDS without wrapping early.
- Protocol requirements:
  - The memory side must never return rvalid without an outstanding grant.
  - mem_gnt_i while mem_req_o = 0 is ignored.

Decomposition:
- Shared package (icache_pkg): ADDR_W = 30, derived OFFSET_W / INDEX_W / TAG_W functions, state encoding {IDLE, REFILL}.
- One sub-module, icache_refill_ctrl. It contains the FSM, req/resp counters, miss latches and drop flag, and generates array write enables and mem_* outputs.
- Arrays and hit compare stay in instruction_cache.
- Counters reuse the existing increment module.

Test Plan:
- Reset, then addr_i = 0x0000_0010 (word 4, line 1 with LINE_WORDS=4) -> ready_o = 0. mem_addr_o issues 4, 5, 6, 7 on successive grants. After the 4th rvalid, ready_o = 1 next cycle and data_o = mem word 4 [31:2].
- After that refill, step addr_i through words 4..7 -> ready_o = 1 every cycle with no mem_req_o, and each data_o matches its word.
- Conflict: addr_i for word 4 and for word 4 + LINES*LINE_WORDS alternate -> each access misses and refills line 1, and tag_array[1] alternates between the two tags.
- Responses lag grants by 3 cycles and grants are gated every other cycle -> exactly 4 requests are issued, data are written in order, and mem_req_o drops after the 4th grant.
- invalidate_i during REFILL on the 2nd rvalid -> the refill finishes but the line is not valid, the next lookup misses and refills, and previously valid lines also miss.
- rst_n_i pulsed low mid-refill, asynchronously between edges -> mem_req_o = 0 and ready_o = 0 immediately, and the same address misses again after release.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared parameters, address-split helpers and refill FSM encoding for the instruction cache.
package icache_pkg;

    localparam int ADDR_W = 30;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int line_words);
        return ADDR_W - index_w(lines) - offset_w(line_words);
    endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Miss handling for the instruction cache: latches the missing line, issues in-order word requests
// and steers returning words into the arrays; stalls lookups (o_idle low) until the line is complete.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_invalidate,
    input  logic                                  i_lookup_hit,
    input  logic [tag_w(LINES, LINE_WORDS)-1:0]   i_lookup_tag,
    input  logic [index_w(LINES)-1:0]             i_lookup_index,
    input  logic                                  i_mem_gnt,
    input  logic                                  i_mem_rvalid,
    output logic                                  o_idle,
    output logic                                  o_mem_req,
    output logic [ADDR_W-1:0]                     o_mem_addr,
    output logic                                  o_data_we,
    output logic [offset_w(LINE_WORDS)-1:0]       o_data_offset,
    output logic                                  o_tag_we,
    output logic                                  o_valid_set,
    output logic [index_w(LINES)-1:0]             o_miss_index,
    output logic [tag_w(LINES, LINE_WORDS)-1:0]   o_miss_tag
);

    localparam int OFFSET_W = offset_w(LINE_WORDS);
    localparam int INDEX_W  = index_w(LINES);
    localparam int TAG_W    = tag_w(LINES, LINE_WORDS);
    localparam int CNT_W    = OFFSET_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_RESP = CNT_W'(LINE_WORDS - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_req_cnt;
    logic [CNT_W-1:0]   r_resp_cnt;
    logic [TAG_W-1:0]   r_miss_tag;
    logic [INDEX_W-1:0] r_miss_index;
    logic               r_drop;
    logic               w_start;
    logic               w_refill;
    logic               w_req;
    logic               w_last_resp;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_refill    = 1'b0;
        w_req       = 1'b0;
        w_last_resp = 1'b0;
        o_data_we   = 1'b0;
        o_tag_we    = 1'b0;
        o_valid_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (!i_lookup_hit && !i_invalidate) begin
                    w_start     = 1'b1;
                    w_state_nxt = REFILL;
                end
            end
            REFILL: begin
                w_refill = 1'b1;
                // MSB of the request counter set means every word has been granted
                w_req    = !r_req_cnt[OFFSET_W];
                if (i_mem_rvalid) begin
                    o_data_we = 1'b1;
                    if (r_resp_cnt == LAST_RESP) begin
                        w_last_resp = 1'b1;
                        o_tag_we    = 1'b1;
                        o_valid_set = !r_drop && !i_invalidate;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_cnt    <= '0;
            r_resp_cnt   <= '0;
            r_miss_tag   <= '0;
            r_miss_index <= '0;
            r_drop       <= 1'b0;
        end else begin
            if (w_start) begin
                r_miss_tag   <= i_lookup_tag;
                r_miss_index <= i_lookup_index;
                r_req_cnt    <= '0;
                r_resp_cnt   <= '0;
            end else if (w_refill) begin
                if (w_req && i_mem_gnt) begin
                    r_req_cnt <= r_req_cnt + CNT_ONE;
                end
                if (i_mem_rvalid) begin
                    r_resp_cnt <= r_resp_cnt + CNT_ONE;
                end
            end
            // a fence.i seen mid-refill must keep the in-flight line from becoming valid
            if (w_last_resp) begin
                r_drop <= 1'b0;
            end else if (w_refill && i_invalidate) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign o_idle        = (r_state == IDLE);
    assign o_mem_req     = w_req;
    assign o_mem_addr    = w_refill ? {r_miss_tag, r_miss_index, r_req_cnt[OFFSET_W-1:0]} : '0;
    assign o_data_offset = r_resp_cnt[OFFSET_W-1:0];
    assign o_miss_index  = r_miss_index;
    assign o_miss_tag    = r_miss_tag;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-latency combinational hit path to the fetch stage;
// ready_o drops on a miss or fence.i and stays low until the whole line has been refilled.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] data_o,
    output logic              ready_o,
    input  logic              invalidate_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int OFFSET_W = offset_w(LINE_WORDS);
    localparam int INDEX_W  = index_w(LINES);
    localparam int TAG_W    = tag_w(LINES, LINE_WORDS);

    logic [OFFSET_W-1:0] w_offset;
    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic                w_idle;
    logic                w_data_we;
    logic [OFFSET_W-1:0] w_data_offset;
    logic                w_tag_we;
    logic                w_valid_set;
    logic [INDEX_W-1:0]  w_miss_index;
    logic [TAG_W-1:0]    w_miss_tag;
    logic                w_unused_rdata;

    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag_array  [LINES];
    logic [ADDR_W-1:0]   r_data_array [LINES*LINE_WORDS];

    assign w_offset = addr_i[OFFSET_W-1:0];
    assign w_index  = addr_i[OFFSET_W +: INDEX_W];
    assign w_tag    = addr_i[ADDR_W-1 -: TAG_W];

    assign w_hit   = r_valid[w_index] && (r_tag_array[w_index] == w_tag);
    assign ready_o = w_idle && w_hit && !invalidate_i;
    assign data_o  = r_data_array[{w_index, w_offset}];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid <= '0;
        end else if (invalidate_i) begin
            r_valid <= '0;
        end else if (w_valid_set) begin
            r_valid[w_miss_index] <= 1'b1;
        end
    end

    // Bits [1:0] of every RV32 non-compressed instruction are 2'b11, so they are not stored
    always_ff @(posedge clk_i) begin
        if (w_tag_we) begin
            r_tag_array[w_miss_index] <= w_miss_tag;
        end
        if (w_data_we) begin
            r_data_array[{w_miss_index, w_data_offset}] <= mem_rdata_i[31:2];
        end
    end

    assign w_unused_rdata = ^mem_rdata_i[1:0];

    icache_refill_ctrl #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_refill_ctrl (
        .i_clk          (clk_i),
        .i_rst_n        (rst_n_i),
        .i_invalidate   (invalidate_i),
        .i_lookup_hit   (w_hit),
        .i_lookup_tag   (w_tag),
        .i_lookup_index (w_index),
        .i_mem_gnt      (mem_gnt_i),
        .i_mem_rvalid   (mem_rvalid_i),
        .o_idle         (w_idle),
        .o_mem_req      (mem_req_o),
        .o_mem_addr     (mem_addr_o),
        .o_data_we      (w_data_we),
        .o_data_offset  (w_data_offset),
        .o_tag_we       (w_tag_we),
        .o_valid_set    (w_valid_set),
        .o_miss_index   (w_miss_index),
        .o_miss_tag     (w_miss_tag)
    );

endmodule
